// File: rtl/div_clk_event_counter_pkg.sv
// Shared definitions for consumers of the divided clock: default width,
// the rise-detector reset level and the counter wrap-value helper.
package div_clk_event_counter_pkg;

    // Default width of count, modulus, load value and period measurement.
    localparam int DEFAULT_WIDTH = 8;

    // div_d resets high so a div_clk held high through reset is not an edge.
    localparam logic DIV_D_RESET = 1'b1;

    // What the counter does in a given cycle.
    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_LOAD = 2'd1,
        ACT_UP   = 2'd2,
        ACT_DOWN = 2'd3
    } cnt_act_e;

    // Largest count value for a given modulus; modulus 0 selects the full
    // 2^width range, so the largest value is all-ones of that width.
    function automatic logic [31:0] wrap_max(input logic [31:0] modulus,
                                             input int unsigned width);
        logic [31:0] all_ones;
        all_ones = 32'hFFFF_FFFF >> (32 - width);
        if (modulus == 32'd0) begin
            return all_ones;
        end
        return modulus - 32'd1;
    endfunction

endpackage

// File: rtl/div_clk_event_counter_rise_detect.sv
// Rising-edge detector for a level that is already synchronous to clk.
// rise is combinational (same cycle div_clk is first seen high); tick is the
// registered one-cycle pulse that follows it.
module rise_detect #(
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic div_clk,
    output logic rise,
    output logic tick
);

    logic div_d;

    assign rise = div_clk & ~div_d;

    // Remember the previous level and register the edge pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_d <= RESET_LEVEL;
            tick  <= 1'b0;
        end else begin
            div_d <= div_clk;
            tick  <= rise;
        end
    end

endmodule

// File: rtl/div_clk_event_counter.sv
// Divided-clock consumer: detects div_clk rising edges, steps a
// programmable-modulus up/down counter on each edge and measures the
// div_clk period, offering each measurement on a valid/ready port with a
// sticky overflow flag for dropped measurements.
module div_clk_event_counter
    import div_clk_event_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_clk,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc,
    output logic             snap_valid,
    output logic [WIDTH-1:0] snap_data,
    input  logic             snap_ready,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic rise;

    rise_detect #(
        .RESET_LEVEL (DIV_D_RESET)
    ) u_rise_detect (
        .clk     (clk),
        .rst     (rst),
        .div_clk (div_clk),
        .rise    (rise),
        .tick    (tick)
    );

    // ------------------------------------------------------------------
    // Modulus counter
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             tc_reg;
    logic             tc_next;
    logic [WIDTH-1:0] wrap_val;
    logic             mod_nz;
    cnt_act_e         act;

    assign wrap_val = WIDTH'(wrap_max(32'(modulus), WIDTH));
    assign mod_nz   = (modulus != '0);

    // Select the counter action: load beats stepping, stepping needs an edge.
    always_comb begin
        act = ACT_HOLD;
        if (load) begin
            act = ACT_LOAD;
        end else if (rise && en) begin
            act = up_dn ? ACT_UP : ACT_DOWN;
        end
    end

    // Next count and wrap pulse; a modulus shrunk below the current count
    // pulls a down-count back into range without signalling a wrap.
    always_comb begin
        count_next = count_reg;
        tc_next    = 1'b0;
        case (act)
            ACT_LOAD: begin
                if (mod_nz && (load_val >= modulus)) begin
                    count_next = wrap_val;
                end else begin
                    count_next = load_val;
                end
            end
            ACT_UP: begin
                if (count_reg >= wrap_val) begin
                    count_next = '0;
                    tc_next    = 1'b1;
                end else begin
                    count_next = count_reg + ONE;
                end
            end
            ACT_DOWN: begin
                if (count_reg == '0) begin
                    count_next = wrap_val;
                    tc_next    = 1'b1;
                end else if (mod_nz && (count_reg >= modulus)) begin
                    count_next = wrap_val;
                end else begin
                    count_next = count_reg - ONE;
                end
            end
            default: begin
                count_next = count_reg;
            end
        endcase
    end

    // Counter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            tc_reg    <= 1'b0;
        end else begin
            count_reg <= count_next;
            tc_reg    <= tc_next;
        end
    end

    assign count = count_reg;
    assign tc    = tc_reg;

    // ------------------------------------------------------------------
    // Period measurement
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] cyc_reg;
    logic [WIDTH-1:0] cyc_inc;
    logic             seen_reg;
    logic             meas_valid;

    // Saturating increment doubles as the measured period sat(cyc+1).
    assign cyc_inc    = (cyc_reg == ALL_ONES) ? ALL_ONES : (cyc_reg + ONE);
    // The first edge after reset only starts the stopwatch.
    assign meas_valid = rise & seen_reg;

    // Cycle stopwatch restarted by every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_reg  <= '0;
            seen_reg <= 1'b0;
        end else begin
            cyc_reg  <= rise ? '0 : cyc_inc;
            seen_reg <= seen_reg | rise;
        end
    end

    // ------------------------------------------------------------------
    // Snapshot handshake
    // ------------------------------------------------------------------
    logic             snap_valid_reg;
    logic             snap_valid_next;
    logic [WIDTH-1:0] snap_data_reg;
    logic [WIDTH-1:0] snap_data_next;
    logic             ovf_reg;
    logic             ovf_next;
    logic             xfer;
    logic             drop;

    assign xfer = snap_valid_reg & snap_ready;
    // A new measurement is lost only when the pending one is not leaving.
    assign drop = meas_valid & snap_valid_reg & ~snap_ready;

    // Next snapshot state; a drop sets ovf even if a clear arrives with it.
    always_comb begin
        snap_valid_next = snap_valid_reg;
        snap_data_next  = snap_data_reg;
        ovf_next        = ovf_reg;
        if (meas_valid && !drop) begin
            snap_data_next  = cyc_inc;
            snap_valid_next = 1'b1;
        end else if (xfer) begin
            snap_valid_next = 1'b0;
        end
        if (drop) begin
            ovf_next = 1'b1;
        end else if (ovf_clr) begin
            ovf_next = 1'b0;
        end
    end

    // Snapshot state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_valid_reg <= 1'b0;
            snap_data_reg  <= '0;
            ovf_reg        <= 1'b0;
        end else begin
            snap_valid_reg <= snap_valid_next;
            snap_data_reg  <= snap_data_next;
            ovf_reg        <= ovf_next;
        end
    end

    assign snap_valid = snap_valid_reg;
    assign snap_data  = snap_data_reg;
    assign ovf        = ovf_reg;

endmodule

// File: tb/tb_div_clk_event_counter.sv
// Self-checking bench for div_clk_event_counter: directed table and
// sequences from the test plan, then randomized stimulus against a
// behavioural model that works in cycle numbers and integer arithmetic.
module tb_div_clk_event_counter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         div_clk;
    logic         en;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] modulus;
    logic [W-1:0] count;
    logic         tick;
    logic         tc;
    logic         snap_valid;
    logic [W-1:0] snap_data;
    logic         snap_ready;
    logic         ovf;
    logic         ovf_clr;

    always #5 clk = ~clk;

    div_clk_event_counter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_clk    (div_clk),
        .en         (en),
        .up_dn      (up_dn),
        .load       (load),
        .load_val   (load_val),
        .modulus    (modulus),
        .count      (count),
        .tick       (tick),
        .tc         (tc),
        .snap_valid (snap_valid),
        .snap_data  (snap_data),
        .snap_ready (snap_ready),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_count, m_data, m_now, m_last;
    bit m_tick, m_tc, m_valid, m_ovf, m_prev;

    // Per-pulse observations
    bit tc_seen, rise_valid;
    int rise_data;

    typedef struct {
        bit din;
        int cnt;
        bit tk;
        bit tcx;
        bit vld;
        int data;
    } vec_t;
    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_tick = 0; m_tc = 0; m_valid = 0; m_data = 0; m_ovf = 0;
        m_prev = 1'b1; m_last = -1; m_now = 0;
    endtask

    // One clock of behaviour from the rules: periods are differences of edge
    // cycle numbers, the counter is modular arithmetic on 0..n-1.
    task automatic model_clock();
        bit rise, have_m, xfer, dropped;
        int n, m;
        rise = div_clk && !m_prev;
        m_prev = div_clk;
        m_tick = rise;
        n = (modulus == 0) ? (1 << W) : int'(modulus);
        m_tc = 0;
        if (load) begin
            m_count = (int'(load_val) >= n) ? n - 1 : int'(load_val);
        end else if (rise && en) begin
            if (up_dn) begin
                if (m_count < n - 1) m_count = m_count + 1;
                else begin m_count = 0; m_tc = 1; end
            end else begin
                if (m_count == 0) begin m_count = n - 1; m_tc = 1; end
                else if (m_count >= n) m_count = n - 1;
                else m_count = m_count - 1;
            end
        end
        have_m = 0; m = 0;
        if (rise) begin
            if (m_last >= 0) begin
                have_m = 1;
                m = m_now - m_last;
                if (m > (1 << W) - 1) m = (1 << W) - 1;
            end
            m_last = m_now;
        end
        m_now++;
        xfer = m_valid && snap_ready;
        dropped = have_m && m_valid && !xfer;
        if (have_m && !dropped) begin m_data = m; m_valid = 1; end
        else if (xfer) m_valid = 0;
        if (dropped) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
    endtask

    task automatic check_all();
        chk("count", count, m_count);
        chk("tick", tick, m_tick);
        chk("tc", tc, m_tc);
        chk("snap_valid", snap_valid, m_valid);
        chk("snap_data", snap_data, m_data);
        chk("ovf", ovf, m_ovf);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else model_clock();
        check_all();
    endtask

    // lows cycles low, then highs cycles high; optional ovf_clr / snap_ready
    // asserted only in the cycle that carries the rising edge.
    task automatic pulse(input int lows, input int highs, input bit clr_at_rise, input bit rdy_at_rise);
        bit base_rdy;
        base_rdy = snap_ready;
        tc_seen = 0;
        div_clk = 1'b0;
        repeat (lows) begin step(); tc_seen |= tc; end
        div_clk = 1'b1;
        if (clr_at_rise) ovf_clr = 1'b1;
        if (rdy_at_rise) snap_ready = 1'b1;
        step();
        tc_seen |= tc;
        rise_valid = snap_valid;
        rise_data = snap_data;
        ovf_clr = 1'b0;
        snap_ready = base_rdy;
        repeat (highs - 1) begin step(); tc_seen |= tc; end
    endtask

    initial begin
        int down_exp[5];
        down_exp = '{3, 2, 1, 0, 4};

        // Divide-by-4, up count, modulus 3: {div_clk, count, tick, tc, valid, data}
        vecs[0]  = '{0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 1, 1, 0, 0, 0};
        vecs[3]  = '{1, 1, 0, 0, 0, 0};
        vecs[4]  = '{0, 1, 0, 0, 0, 0};
        vecs[5]  = '{0, 1, 0, 0, 0, 0};
        vecs[6]  = '{1, 2, 1, 0, 1, 4};
        vecs[7]  = '{1, 2, 0, 0, 0, 4};
        vecs[8]  = '{0, 2, 0, 0, 0, 4};
        vecs[9]  = '{0, 2, 0, 0, 0, 4};
        vecs[10] = '{1, 0, 1, 1, 1, 4};
        vecs[11] = '{1, 0, 0, 0, 0, 4};
        vecs[12] = '{0, 0, 0, 0, 0, 4};
        vecs[13] = '{0, 0, 0, 0, 0, 4};
        vecs[14] = '{1, 1, 1, 0, 1, 4};
        vecs[15] = '{1, 1, 0, 0, 0, 4};

        // Reset with div_clk high, then hold high: no edge, no tick
        rst = 1'b1; div_clk = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b0;
        load_val = '0; modulus = 8'd3; snap_ready = 1'b1; ovf_clr = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_tick", tick, 0);
            chk("hold_count", count, 0);
            chk("hold_valid", snap_valid, 0);
        end

        // Table: up count modulo 3 with divide-by-4 input
        for (int i = 0; i < 16; i++) begin
            div_clk = vecs[i].din;
            step();
            chk($sformatf("tbl%0d_count", i), count, vecs[i].cnt);
            chk($sformatf("tbl%0d_tick", i), tick, vecs[i].tk);
            chk($sformatf("tbl%0d_tc", i), tc, vecs[i].tcx);
            chk($sformatf("tbl%0d_valid", i), snap_valid, vecs[i].vld);
            chk($sformatf("tbl%0d_data", i), snap_data, vecs[i].data);
        end

        // Down count, modulus 5, out-of-range load clamps to 4
        modulus = 8'd5; up_dn = 1'b0; load = 1'b1; load_val = 8'd9;
        step();
        load = 1'b0;
        chk("load_clamp", count, 4);
        chk("load_tc", tc, 0);
        for (int i = 0; i < 5; i++) begin
            pulse(2, 2, 0, 0);
            chk($sformatf("down%0d_count", i), count, down_exp[i]);
            chk($sformatf("down%0d_tc", i), tc_seen, (i == 4) ? 1 : 0);
        end

        // Back-pressure: hold first, drop second, set beats clear, clear alone
        snap_ready = 1'b0;
        pulse(2, 2, 0, 0);
        chk("bp_first_valid", rise_valid, 1);
        chk("bp_first_data", rise_data, 4);
        pulse(2, 2, 0, 0);
        chk("bp_drop_data", snap_data, 4);
        chk("bp_drop_ovf", ovf, 1);
        pulse(2, 2, 1, 0);
        chk("bp_set_wins", ovf, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("bp_clr_ovf", ovf, 0);
        chk("bp_clr_data", snap_data, 4);

        // Accept in the same cycle a new measurement arrives
        pulse(2, 2, 0, 1);
        chk("xfer_new_valid", rise_valid, 1);
        chk("xfer_new_data", rise_data, 5);

        // Long static level saturates the period
        snap_ready = 1'b1;
        pulse(300, 2, 0, 0);
        chk("sat_valid", rise_valid, 1);
        chk("sat_data", rise_data, 255);

        // Asynchronous reset mid-count
        div_clk = 1'b0;
        step();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_count", count, 0);
        chk("arst_tick", tick, 0);
        chk("arst_tc", tc, 0);
        chk("arst_valid", snap_valid, 0);
        chk("arst_data", snap_data, 0);
        chk("arst_ovf", ovf, 0);
        step();
        rst = 1'b0;
        pulse(2, 2, 0, 0);
        chk("post_rst_first", rise_valid, 0);
        pulse(2, 2, 0, 0);
        chk("post_rst_second_valid", rise_valid, 1);
        chk("post_rst_second_data", rise_data, 4);

        // Randomized stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 3) == 0) div_clk = ~div_clk;
            en = ($urandom_range(0, 3) != 0);
            up_dn = 1'($urandom_range(0, 1));
            load = ($urandom_range(0, 24) == 0);
            load_val = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 79) == 0) begin
                case ($urandom_range(0, 5))
                    0: modulus = 8'd0;
                    1: modulus = 8'd1;
                    2: modulus = 8'd2;
                    3: modulus = 8'd5;
                    4: modulus = 8'd200;
                    default: modulus = 8'($urandom_range(0, 255));
                endcase
            end
            snap_ready = ($urandom_range(0, 2) != 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
